// File: rtl/memory_arbiter.sv
// memory_arbiter: N-port front end for memory_unit. Each requester raises its
// own req_execute; one winner is chosen (fixed priority or round-robin), its
// command is registered onto the memory handshake, and completion returns
// rd_data plus a one-cycle req_done pulse to that port. A per-port lock keeps
// the grant on the owner between transactions.

`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif

module memory_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = `MEMORY_ADDR_WIDTH,
    parameter int DATA_WIDTH = `MEMORY_DATA_WIDTH,
    parameter int FUNC_WIDTH = 2,
    parameter int ARB_MODE   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_execute,
    input  logic [NUM_PORTS-1:0]            req_lock,
    input  logic [NUM_PORTS*FUNC_WIDTH-1:0] req_func,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_write_data,
    output logic [NUM_PORTS-1:0]            req_done,
    output logic [NUM_PORTS-1:0]            grant,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            busy,
    output logic                            mem_execute,
    output logic [FUNC_WIDTH-1:0]           mem_func,
    output logic [ADDR_WIDTH-1:0]           mem_address,
    output logic [DATA_WIDTH-1:0]           mem_write_data,
    input  logic                            mem_ready,
    input  logic [DATA_WIDTH-1:0]           mem_read_data
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [NUM_PORTS-1:0]  grant_q, grant_d;
    logic [NUM_PORTS-1:0]  req_done_q, req_done_d;
    logic                  busy_q, busy_d;
    logic                  mem_execute_q, mem_execute_d;
    logic [FUNC_WIDTH-1:0] mem_func_q, mem_func_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_write_data_q, mem_write_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic                  lock_valid_q, lock_valid_d;

    // Per-port views of the packed request buses.
    logic [FUNC_WIDTH-1:0] func_arr  [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign func_arr[gi]  = req_func[gi*FUNC_WIDTH +: FUNC_WIDTH];
        assign addr_arr[gi]  = req_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[gi] = req_write_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [NUM_PORTS-1:0]  owner_oh;
    logic [NUM_PORTS-1:0]  win_oh;
    logic [IDX_W-1:0]      owner_next;
    logic                  lock_active;
    logic [NUM_PORTS-1:0]  eligible;
    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    logic [FUNC_WIDTH-1:0] win_func;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    assign owner_oh   = {{(NUM_PORTS-1){1'b0}}, 1'b1} << owner_q;
    assign win_oh     = {{(NUM_PORTS-1){1'b0}}, 1'b1} << win_idx;
    assign owner_next = (owner_q == IDX_W'(NUM_PORTS-1)) ? '0 : owner_q + IDX_W'(1);

    // The lock only holds while the owner keeps its req_lock high; the cycle it
    // drops, every port is eligible again in that same IDLE cycle.
    assign lock_active = lock_valid_q && |(req_lock & owner_oh);
    assign eligible    = lock_active ? (req_execute & owner_oh) : req_execute;

    // Winner search: smallest distance from the start index, wrapping modulo
    // NUM_PORTS. Fixed priority is simply a search that always starts at 0.
    always_comb begin
        int start_i;
        int dist_i;
        int best_i;
        start_i   = (ARB_MODE == 1) ? int'(rr_ptr_q) : 0;
        best_i    = NUM_PORTS;
        dist_i    = 0;
        win_found = 1'b0;
        win_idx   = '0;
        win_func  = '0;
        win_addr  = '0;
        win_wdata = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            dist_i = j - start_i;
            if (dist_i < 0) begin
                dist_i = dist_i + NUM_PORTS;
            end
            if (eligible[j] && (dist_i < best_i)) begin
                best_i    = dist_i;
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
                win_func  = func_arr[j];
                win_addr  = addr_arr[j];
                win_wdata = wdata_arr[j];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mem_ready && win_found) state_d = S_ISSUE;
            S_ISSUE: if (!mem_ready)             state_d = S_WAIT;
            S_WAIT:  if (mem_ready)              state_d = S_DONE;
            S_DONE:                              state_d = S_IDLE;
            default:                             state_d = S_IDLE;
        endcase
    end

    // FSM outputs and datapath: next values for every registered output.
    always_comb begin
        grant_d          = grant_q;
        req_done_d       = '0;
        busy_d           = busy_q;
        mem_execute_d    = mem_execute_q;
        mem_func_d       = mem_func_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        rd_data_d        = rd_data_q;
        rr_ptr_d         = rr_ptr_q;
        owner_d          = owner_q;
        lock_valid_d     = lock_valid_q;
        case (state_q)
            S_IDLE: begin
                if (lock_valid_q && !lock_active) begin
                    lock_valid_d = 1'b0;
                    grant_d      = '0;
                end
                if (mem_ready && win_found) begin
                    owner_d          = win_idx;
                    grant_d          = win_oh;
                    busy_d           = 1'b1;
                    mem_execute_d    = 1'b1;
                    mem_func_d       = win_func;
                    mem_address_d    = win_addr;
                    mem_write_data_d = win_wdata;
                end
            end
            S_ISSUE: begin
                if (!mem_ready) begin
                    mem_execute_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    rd_data_d    = mem_read_data;
                    req_done_d   = owner_oh;
                    rr_ptr_d     = owner_next;
                    lock_valid_d = |(req_lock & owner_oh);
                end
            end
            S_DONE: begin
                busy_d = 1'b0;
                if (!lock_valid_q) begin
                    grant_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and arbitration state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q          <= '0;
            req_done_q       <= '0;
            busy_q           <= 1'b0;
            mem_execute_q    <= 1'b0;
            mem_func_q       <= '0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            rd_data_q        <= '0;
            rr_ptr_q         <= '0;
            owner_q          <= '0;
            lock_valid_q     <= 1'b0;
        end else begin
            grant_q          <= grant_d;
            req_done_q       <= req_done_d;
            busy_q           <= busy_d;
            mem_execute_q    <= mem_execute_d;
            mem_func_q       <= mem_func_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            rd_data_q        <= rd_data_d;
            rr_ptr_q         <= rr_ptr_d;
            owner_q          <= owner_d;
            lock_valid_q     <= lock_valid_d;
        end
    end

    assign grant          = grant_q;
    assign req_done       = req_done_q;
    assign busy           = busy_q;
    assign mem_execute    = mem_execute_q;
    assign mem_func       = mem_func_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign rd_data        = rd_data_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a 2-port fixed-priority instance (A) and a
// 3-port round-robin instance (B), each in front of a small memory model whose
// read data is 0x122F + address and which holds mem_ready low for 3 cycles.

module tb_memory_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int FW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int tests    = 0;
    int failures = 0;

    // ---------------- instance A: 2 ports, fixed priority ----------------
    logic [1:0]      a_req_execute = '0;
    logic [1:0]      a_req_lock    = '0;
    logic [2*FW-1:0] a_req_func    = '0;
    logic [2*AW-1:0] a_req_address = '0;
    logic [2*DW-1:0] a_req_write_data = '0;
    logic [1:0]      a_req_done, a_grant;
    logic [DW-1:0]   a_rd_data, a_mem_write_data, a_mem_read_data;
    logic            a_busy, a_mem_execute, a_mem_ready;
    logic [FW-1:0]   a_mem_func;
    logic [AW-1:0]   a_mem_address;

    memory_arbiter #(
        .NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FUNC_WIDTH(FW), .ARB_MODE(0)
    ) u_a (
        .clk(clk), .rst(rst),
        .req_execute(a_req_execute), .req_lock(a_req_lock), .req_func(a_req_func),
        .req_address(a_req_address), .req_write_data(a_req_write_data),
        .req_done(a_req_done), .grant(a_grant), .rd_data(a_rd_data), .busy(a_busy),
        .mem_execute(a_mem_execute), .mem_func(a_mem_func), .mem_address(a_mem_address),
        .mem_write_data(a_mem_write_data), .mem_ready(a_mem_ready),
        .mem_read_data(a_mem_read_data)
    );

    // ---------------- instance B: 3 ports, round-robin ----------------
    logic [2:0]      b_req_execute = '0;
    logic [2:0]      b_req_lock    = '0;
    logic [3*FW-1:0] b_req_func    = '0;
    logic [3*AW-1:0] b_req_address = '0;
    logic [3*DW-1:0] b_req_write_data = '0;
    logic [2:0]      b_req_done, b_grant;
    logic [DW-1:0]   b_rd_data, b_mem_write_data, b_mem_read_data;
    logic            b_busy, b_mem_execute, b_mem_ready;
    logic [FW-1:0]   b_mem_func;
    logic [AW-1:0]   b_mem_address;

    memory_arbiter #(
        .NUM_PORTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FUNC_WIDTH(FW), .ARB_MODE(1)
    ) u_b (
        .clk(clk), .rst(rst),
        .req_execute(b_req_execute), .req_lock(b_req_lock), .req_func(b_req_func),
        .req_address(b_req_address), .req_write_data(b_req_write_data),
        .req_done(b_req_done), .grant(b_grant), .rd_data(b_rd_data), .busy(b_busy),
        .mem_execute(b_mem_execute), .mem_func(b_mem_func), .mem_address(b_mem_address),
        .mem_write_data(b_mem_write_data), .mem_ready(b_mem_ready),
        .mem_read_data(b_mem_read_data)
    );

    // ---------------- memory models ----------------
    int            a_cnt;
    int            a_accepts;
    logic [AW-1:0] a_pend_addr, a_last_addr;
    logic [DW-1:0] a_last_wd;
    logic [FW-1:0] a_last_func;

    always @(posedge clk) begin
        if (!rst) begin
            a_mem_ready     <= 1'b1;
            a_mem_read_data <= '0;
            a_cnt           <= 0;
            a_accepts       <= 0;
            a_pend_addr     <= '0;
            a_last_addr     <= '0;
            a_last_wd       <= '0;
            a_last_func     <= '0;
        end else if (a_mem_ready && a_mem_execute) begin
            a_mem_ready <= 1'b0;
            a_cnt       <= 2;
            a_accepts   <= a_accepts + 1;
            a_pend_addr <= a_mem_address;
            a_last_addr <= a_mem_address;
            a_last_wd   <= a_mem_write_data;
            a_last_func <= a_mem_func;
        end else if (!a_mem_ready) begin
            if (a_cnt == 0) begin
                a_mem_ready     <= 1'b1;
                a_mem_read_data <= 16'h122F + {8'h00, a_pend_addr};
            end else begin
                a_cnt <= a_cnt - 1;
            end
        end
    end

    int            b_cnt;
    logic [AW-1:0] b_pend_addr;

    always @(posedge clk) begin
        if (!rst) begin
            b_mem_ready     <= 1'b1;
            b_mem_read_data <= '0;
            b_cnt           <= 0;
            b_pend_addr     <= '0;
        end else if (b_mem_ready && b_mem_execute) begin
            b_mem_ready <= 1'b0;
            b_cnt       <= 2;
            b_pend_addr <= b_mem_address;
        end else if (!b_mem_ready) begin
            if (b_cnt == 0) begin
                b_mem_ready     <= 1'b1;
                b_mem_read_data <= 16'h122F + {8'h00, b_pend_addr};
            end else begin
                b_cnt <= b_cnt - 1;
            end
        end
    end

    // Done pulses seen by each port of A over the whole run.
    int a_done0 = 0;
    int a_done1 = 0;
    always @(posedge clk) begin
        if (a_req_done[0]) a_done0 <= a_done0 + 1;
        if (a_req_done[1]) a_done1 <= a_done1 + 1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_a_done(output logic [1:0] which, output int cyc);
        which = '0;
        cyc   = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (a_req_done != 2'b00) begin
                which = a_req_done;
                cyc   = k;
                break;
            end
        end
    endtask

    task automatic wait_b_done(output logic [2:0] which);
        which = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (b_req_done != 3'b000) begin
                which = b_req_done;
                break;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    logic [1:0]  a_which;
    logic [2:0]  b_which;
    int          cyc;
    logic [2:0]  rr_exp  [6];
    logic [15:0] rr_data [6];

    initial begin
        rr_exp  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rr_data = '{16'h1239, 16'h123A, 16'h123B, 16'h1239, 16'h123A, 16'h123B};

        // Reset state.
        tick(3);
        check("rst_a_grant", a_grant, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_exec", a_mem_execute, 0);
        check("rst_a_done", a_req_done, 0);
        check("rst_a_rd", a_rd_data, 0);
        check("rst_a_addr", a_mem_address, 0);
        check("rst_b_grant", b_grant, 0);
        check("rst_b_busy", b_busy, 0);
        rst = 1'b1;
        tick(2);

        // Single read from port 1 at address 5.
        a_req_func[3:2]    = 2'b00;
        a_req_address[15:8] = 8'd5;
        a_req_execute[1]   = 1'b1;
        tick(1);
        check("t1_grant", a_grant, 2'b10);
        check("t1_addr", a_mem_address, 8'd5);
        check("t1_exec", a_mem_execute, 1);
        check("t1_busy", a_busy, 1);
        wait_a_done(a_which, cyc);
        check("t1_done", a_which, 2'b10);
        check("t1_latency", cyc, 5);
        check("t1_rd", a_rd_data, 16'h1234);
        check("t1_busy_done", a_busy, 1);
        a_req_execute[1] = 1'b0;
        tick(1);
        check("t1_busy_clr", a_busy, 0);
        check("t1_grant_clr", a_grant, 0);
        check("t1_done_clr", a_req_done, 0);

        // Fixed priority: port 0 writes three times while port 1 waits.
        a_req_func[1:0]      = 2'b01;
        a_req_write_data[15:0] = 16'hAAAA;
        a_req_address[7:0]   = 8'd1;
        a_req_address[15:8]  = 8'd2;
        a_req_func[3:2]      = 2'b00;
        a_req_execute        = 2'b11;
        for (int r = 0; r < 3; r++) begin
            wait_a_done(a_which, cyc);
            check($sformatf("t2_done_r%0d", r), a_which, 2'b01);
            check($sformatf("t2_addr_r%0d", r), a_last_addr, 8'(r + 1));
            check($sformatf("t2_wd_r%0d", r), a_last_wd, 16'hAAAA);
            a_req_address[7:0] = 8'(r + 2);
        end
        a_req_execute[0] = 1'b0;
        wait_a_done(a_which, cyc);
        check("t2_p1_done", a_which, 2'b10);
        check("t2_p1_rd", a_rd_data, 16'h1231);
        a_req_execute[1] = 1'b0;
        tick(1);

        // Round-robin on B: all three ports request continuously.
        b_req_address = {8'd12, 8'd11, 8'd10};
        b_req_func    = '0;
        b_req_execute = 3'b111;
        for (int r = 0; r < 6; r++) begin
            wait_b_done(b_which);
            check($sformatf("t3_order_%0d", r), b_which, rr_exp[r]);
            check($sformatf("t3_rd_%0d", r), b_rd_data, rr_data[r]);
        end
        b_req_execute = 3'b000;
        tick(1);
        check("t3_grant_clr", b_grant, 0);

        // Lock: port 1 holds the memory for two writes while port 0 waits.
        a_req_func[3:2]         = 2'b01;
        a_req_address[15:8]     = 8'd7;
        a_req_write_data[31:16] = 16'h5555;
        a_req_lock[1]           = 1'b1;
        a_req_execute[1]        = 1'b1;
        tick(1);
        check("t4_grant_p1", a_grant, 2'b10);
        a_req_func[1:0]    = 2'b00;
        a_req_address[7:0] = 8'd8;
        a_req_execute[0]   = 1'b1;
        wait_a_done(a_which, cyc);
        check("t4_done1", a_which, 2'b10);
        check("t4_wd1", a_last_wd, 16'h5555);
        a_req_write_data[31:16] = 16'h6666;
        wait_a_done(a_which, cyc);
        check("t4_done2", a_which, 2'b10);
        check("t4_wd2", a_last_wd, 16'h6666);
        check("t4_func2", a_last_func, 2'b01);
        a_req_execute[1] = 1'b0;
        tick(4);
        check("t4_hold_grant", a_grant, 2'b10);
        check("t4_hold_busy", a_busy, 0);
        check("t4_hold_exec", a_mem_execute, 0);
        a_req_lock[1] = 1'b0;
        tick(1);
        check("t4_p0_grant", a_grant, 2'b01);
        check("t4_p0_addr", a_mem_address, 8'd8);
        wait_a_done(a_which, cyc);
        check("t4_p0_done", a_which, 2'b01);
        check("t4_p0_rd", a_rd_data, 16'h1237);
        a_req_execute[0] = 1'b0;
        tick(1);
        check("t4_grant_clr", a_grant, 0);

        // Reset while waiting for memory.
        a_req_address[7:0] = 8'd3;
        a_req_execute[0]   = 1'b1;
        tick(3);
        check("t5_wait_exec", a_mem_execute, 0);
        check("t5_wait_busy", a_busy, 1);
        rst = 1'b0;
        #1;
        check("t5_rst_grant", a_grant, 0);
        check("t5_rst_busy", a_busy, 0);
        check("t5_rst_addr", a_mem_address, 0);
        check("t5_rst_rd", a_rd_data, 0);
        a_req_execute[0] = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2);
        check("t5_no_done", a_done0, 4);
        check("t5_idle_grant", a_grant, 0);
        check("t5_idle_exec", a_mem_execute, 0);
        a_req_func[3:2]     = 2'b00;
        a_req_address[15:8] = 8'd6;
        a_req_execute[1]    = 1'b1;
        wait_a_done(a_which, cyc);
        check("t5_after_done", a_which, 2'b10);
        check("t5_after_rd", a_rd_data, 16'h1235);
        a_req_execute[1] = 1'b0;
        tick(1);

        // Port 0 withdraws its request right after acceptance.
        a_req_address[7:0] = 8'd9;
        a_req_execute[0]   = 1'b1;
        tick(1);
        check("t6_grant", a_grant, 2'b01);
        tick(1);
        a_req_execute[0] = 1'b0;
        wait_a_done(a_which, cyc);
        check("t6_done", a_which, 2'b01);
        check("t6_rd", a_rd_data, 16'h1238);
        tick(4);
        check("t6_accepts", a_accepts, 2);
        check("t6_busy", a_busy, 0);
        check("t6_grant_clr", a_grant, 0);
        check("t6_done0_cnt", a_done0, 5);
        check("t6_done1_cnt", a_done1, 5);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
